io1_pad_arbiter: RTL

Owns one bidirectional top-level pad of an IO tile. It shares the pad's output driver among four fabric requesters with round-robin arbitration, a bounded hold time and a forced turnaround gap. It also returns the pad's input value, double-synchronised, to all four fabric pins. It sits between the fabric routing tracks and the pad cell, and is the only block allowed to drive the pad's output enable.

---
 rtl/io_pad_pkg.sv | 21 ++
 rtl/io_rr_arbiter.sv | 27 ++
 rtl/io1_pad_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/io_pad_pkg.sv
// rtl/io_pad_pkg.sv - shared types and widths for the IO pad arbiter tile
package io_pad_pkg;

  localparam int N_REQ  = 4;
  localparam int HOLD_W = 8;
  localparam int TURN_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/io_rr_arbiter.sv
// rtl/io_rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
module io_rr_arbiter
  import io_pad_pkg::*;
(
  input  logic [N_REQ-1:0] ereq,
  input  logic [1:0]       rr_ptr,
  output logic [1:0]       winner,
  output logic             valid
);

  logic [1:0] idx;

  // First set bit scanning upward from rr_ptr, wrapping modulo 4.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = rr_ptr + 2'(i);
      if (!valid && ereq[idx]) begin
        winner = idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io1_pad_arbiter.sv
// rtl/io1_pad_arbiter.sv - shares one bidirectional pad driver among four fabric requesters
module io1_pad_arbiter
  import io_pad_pkg::*;
#(
  parameter int TURNAROUND = 1,
  parameter int HOLD_MAX   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] cfg_en,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] dout,
  output logic [N_REQ-1:0] grant,
  input  logic             pad_in,
  output logic             pad_out,
  output logic             pad_oe,
  output logic [N_REQ-1:0] pin
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
  localparam logic [TURN_W-1:0] TURN_LIM = TURN_W'(TURNAROUND);

  state_t            state;
  logic [1:0]        owner;
  logic [1:0]        rr_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TURN_W-1:0] turn_cnt;
  logic              s1;
  logic              s2;

  logic [N_REQ-1:0]  ereq;
  logic [N_REQ-1:0]  owner_mask;
  logic [1:0]        winner;
  logic              win_valid;
  logic              release_c;
  logic              preempt_c;

  assign ereq       = req & cfg_en;
  assign owner_mask = onehot(owner);
  assign release_c  = ~ereq[owner];
  // Hold limit only matters when someone else is waiting.
  assign preempt_c  = (hold_cnt == HOLD_LIM) && (|(ereq & ~owner_mask));

  io_rr_arbiter u_rr (
    .ereq   (ereq),
    .rr_ptr (rr_ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      turn_cnt <= '0;
      grant    <= '0;
      pad_oe   <= 1'b0;
      pad_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            owner    <= winner;
            grant    <= onehot(winner);
            pad_oe   <= 1'b1;
            pad_out  <= dout[winner];
            hold_cnt <= HOLD_W'(1);
            state    <= DRIVE;
          end else begin
            grant   <= '0;
            pad_oe  <= 1'b0;
            pad_out <= 1'b0;
          end
        end
        DRIVE: begin
          if (release_c || preempt_c) begin
            grant    <= '0;
            pad_oe   <= 1'b0;
            pad_out  <= 1'b0;
            rr_ptr   <= owner + 2'd1;
            turn_cnt <= TURN_W'(1);
            state    <= TURN;
          end else begin
            pad_out <= dout[owner];
            if (hold_cnt != HOLD_LIM) begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end
        TURN: begin
          grant  <= '0;
          pad_oe <= 1'b0;
          if (turn_cnt == TURN_LIM) begin
            state <= IDLE;
          end else begin
            turn_cnt <= turn_cnt + TURN_W'(1);
          end
        end
        default: begin
          state   <= IDLE;
          grant   <= '0;
          pad_oe  <= 1'b0;
          pad_out <= 1'b0;
        end
      endcase
    end
  end

  // Two-flop synchroniser; runs regardless of who owns the driver.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pad_in;
      s2 <= s1;
    end
  end

  assign pin = {N_REQ{s2}};

endmodule
